// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: PS/2 key events drive a CLOCK/RUN/PAUSE/LAP FSM, the count-enable tick and display controls.
// Define STOPWATCH_AUTO_IDLE_EN to build the PAUSE -> CLOCK idle timeout.
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned IDLE_TIMEOUT = 30,
  parameter logic [7:0]  KEY_RUN      = 8'h29,
  parameter logic [7:0]  KEY_LAP      = 8'h5A,
  parameter logic [7:0]  KEY_CLR      = 8'h76
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [7:0] kbd_code,
  input  logic       kbd_valid,
  input  logic       kbd_release,
  output logic       sw_tick,
  output logic       sw_clear,
  output logic       disp_sel,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned K_RUN = 0;
  localparam int unsigned K_LAP = 1;
  localparam int unsigned K_CLR = 2;

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0 || IDLE_TIMEOUT < 1) begin : g_cfg_check
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2 and IDLE_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_CLOCK = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    hit_c, press_c, held_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_c, presc_wrap_c, idle_timeout_c;
  logic          sw_tick_d, sw_clear_d, disp_sel_d, lap_hold_d;

  // Key decode; a make code only counts as a press while that key is not already held
  assign hit_c   = {3{kbd_valid}} & {kbd_code == KEY_CLR, kbd_code == KEY_LAP, kbd_code == KEY_RUN};
  assign press_c = hit_c & ~held_q & {3{~kbd_release}};

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      held_q <= '0;
    end else begin
      held_q <= (held_q & ~hit_c) | (hit_c & {3{~kbd_release}});
    end
  end

  assign running_c    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign presc_wrap_c = (presc_q == PW'(DIV - 1));

`ifdef STOPWATCH_AUTO_IDLE_EN
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  // Own phase counter: the run prescaler is frozen while paused
  logic [PW-1:0] idle_div_q;
  logic [IW-1:0] idle_cnt_q;
  logic          idle_wrap_c;

  assign idle_wrap_c    = (idle_div_q == PW'(DIV - 1));
  assign idle_timeout_c = (state_q == ST_PAUSE) && idle_wrap_c &&
                          (idle_cnt_q == IW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      idle_div_q <= '0;
      idle_cnt_q <= '0;
    end else if (state_q != ST_PAUSE || state_d != ST_PAUSE) begin
      idle_div_q <= '0;
      idle_cnt_q <= '0;
    end else if (idle_wrap_c) begin
      idle_div_q <= '0;
      idle_cnt_q <= idle_cnt_q + IW'(1);
    end else begin
      idle_div_q <= idle_div_q + PW'(1);
    end
  end
`else
  assign idle_timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLOCK: begin
        if (press_c[K_RUN]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_c[K_CLR])      state_d = ST_CLOCK;
        else if (press_c[K_RUN]) state_d = ST_PAUSE;
        else if (press_c[K_LAP]) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (press_c[K_CLR])      state_d = ST_CLOCK;
        else if (press_c[K_RUN]) state_d = ST_PAUSE;
        else if (press_c[K_LAP]) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (press_c[K_CLR])      state_d = ST_CLOCK;
        else if (press_c[K_RUN]) state_d = ST_RUN;
        else if (idle_timeout_c) state_d = ST_CLOCK;
      end
      default: state_d = ST_CLOCK;
    endcase
  end

  // Output and prescaler decode; the tick follows the current state so a leaving press still gets it
  always_comb begin
    sw_tick_d  = 1'b0;
    sw_clear_d = 1'b0;
    disp_sel_d = 1'b1;
    lap_hold_d = 1'b0;
    presc_d    = presc_q;
    if (running_c) begin
      sw_tick_d = presc_wrap_c;
      presc_d   = presc_wrap_c ? '0 : presc_q + PW'(1);
    end
    case (state_d)
      ST_CLOCK: begin
        sw_clear_d = 1'b1;
        disp_sel_d = 1'b0;
        presc_d    = '0;
      end
      ST_LAP:  lap_hold_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      sw_tick  <= 1'b0;
      sw_clear <= 1'b1;
      disp_sel <= 1'b0;
      lap_hold <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      sw_tick  <= sw_tick_d;
      sw_clear <= sw_clear_d;
      disp_sel <= disp_sel_d;
      lap_hold <= lap_hold_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DIV=10, IDLE_TIMEOUT=3.
// Stimulus pushes timed output snapshots and tick times; a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_ESC   = 8'h76;
  localparam logic [1:0] S_CLOCK = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;
  localparam int unsigned T = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] kbd_code = '0;
  logic       kbd_valid = 1'b0;
  logic       kbd_release = 1'b0;
  logic       sw_tick, sw_clear, disp_sel, lap_hold;
  logic [1:0] state;

  stopwatch_ctrl #(
    .CLK_HZ(100), .TICK_HZ(10), .IDLE_TIMEOUT(3)
  ) dut (
    .clk_100MHz (clk),
    .reset      (rst_n),
    .kbd_code   (kbd_code),
    .kbd_valid  (kbd_valid),
    .kbd_release(kbd_release),
    .sw_tick    (sw_tick),
    .sw_clear   (sw_clear),
    .disp_sel   (disp_sel),
    .lap_hold   (lap_hold),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [5:0]  vec;
    string       tag;
  } snap_t;

  snap_t       snap_q[$];
  int unsigned tick_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_at(input int unsigned at, input logic [1:0] st, input logic t,
                                 input logic c, input logic d, input logic l, input string tag);
    snap_t s;
    s.at  = at;
    s.vec = {st, t, c, d, l};
    s.tag = tag;
    snap_q.push_back(s);
  endfunction

  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle key strobe in cycle c
  task automatic key(input int unsigned c, input logic [7:0] code, input logic rel);
    goto(c);
    if (cyc != c) begin
      $display("FAIL schedule: key due at cycle %0d, now %0d", c, cyc);
      $fatal(1, "bench schedule broken");
    end
    kbd_code    = code;
    kbd_release = rel;
    kbd_valid   = 1'b1;
    @(posedge clk);
    #1;
    kbd_valid   = 1'b0;
  endtask

  // Monitor: snapshots due this cycle, every observed tick against the expected tick times
  always @(negedge clk) begin
    logic [5:0] got;
    snap_t      s;
    got = {state, sw_tick, sw_clear, disp_sel, lap_hold};
    while (snap_q.size() != 0 && snap_q[0].at <= cyc) begin
      s = snap_q.pop_front();
      checks++;
      if (s.at != cyc || got !== s.vec) begin
        errors++;
        $display("FAIL %s: cycle %0d (due %0d) state/tick/clr/disp/lap got %b required %b",
                 s.tag, cyc, s.at, got, s.vec);
      end
    end
    while (tick_q.size() != 0 && tick_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL tick_missing: sw_tick required at cycle %0d did not occur (now %0d)", tick_q[0], cyc);
      void'(tick_q.pop_front());
    end
    if (sw_tick === 1'b1) begin
      checks++;
      if (tick_q.size() == 0 || tick_q[0] != cyc) begin
        errors++;
        $display("FAIL tick_unexpected: sw_tick=1 at cycle %0d, next expected %0d", cyc,
                 (tick_q.size() != 0) ? tick_q[0] : 0);
      end else begin
        void'(tick_q.pop_front());
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (snap_q.size() != 0) begin
        errors++;
        $display("FAIL snap_leftover: %0d snapshots never compared, required 0", snap_q.size());
      end
      checks++;
      if (tick_q.size() != 0) begin
        errors++;
        $display("FAIL tick_leftover: %0d ticks still pending, required 0", tick_q.size());
      end
      end_done = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    @(posedge clk);
    #1;
    exp_at(cyc, S_CLOCK, 0, 1, 0, 0, "reset_vals");
    exp_at(cyc + 1, S_CLOCK, 0, 1, 0, 0, "reset_vals_hold");
    goto(3);
    rst_n = 1'b1;

    // Start, typematic repeats, pause
    key(T + 0, K_SPACE, 0);
    exp_at(T + 1, S_RUN, 0, 0, 1, 0, "run_entry");
    exp_at(T + 11, S_RUN, 1, 0, 1, 0, "first_tick");
    tick_q.push_back(T + 11);
    key(T + 12, K_SPACE, 0);
    key(T + 14, K_SPACE, 0);
    exp_at(T + 15, S_RUN, 0, 0, 1, 0, "repeat_ignored");
    key(T + 16, K_SPACE, 1);
    key(T + 18, K_SPACE, 0);
    exp_at(T + 19, S_PAUSE, 0, 0, 1, 0, "pause_entry");
    key(T + 20, K_SPACE, 1);
    exp_at(T + 25, S_PAUSE, 0, 0, 1, 0, "pause_hold");

    // Resume from frozen prescaler value 8: tick two cycles later
    key(T + 30, K_SPACE, 0);
    exp_at(T + 31, S_RUN, 0, 0, 1, 0, "resume");
    exp_at(T + 33, S_RUN, 1, 0, 1, 0, "resume_tick");
    tick_q.push_back(T + 33);
    key(T + 32, K_SPACE, 1);

    // Lap hold and release, ticks continue
    key(T + 35, K_ENTER, 0);
    exp_at(T + 36, S_LAP, 0, 0, 1, 1, "lap_entry");
    exp_at(T + 43, S_LAP, 1, 0, 1, 1, "lap_tick");
    tick_q.push_back(T + 43);
    key(T + 37, K_ENTER, 1);
    key(T + 45, K_ENTER, 0);
    exp_at(T + 46, S_RUN, 0, 0, 1, 0, "lap_release");

    // Space on the prescaler-9 cycle: tick still issued alongside PAUSE
    key(T + 52, K_SPACE, 0);
    exp_at(T + 53, S_PAUSE, 1, 0, 1, 0, "tick_and_pause");
    tick_q.push_back(T + 53);
    key(T + 55, K_SPACE, 1);
    key(T + 57, K_SPACE, 0);
    exp_at(T + 58, S_RUN, 0, 0, 1, 0, "resume_zero");
    key(T + 60, K_SPACE, 1);

    // Esc on the prescaler-9 cycle: tick plus clear
    key(T + 67, K_ESC, 0);
    exp_at(T + 68, S_CLOCK, 1, 1, 0, 0, "esc_with_tick");
    exp_at(T + 69, S_CLOCK, 0, 1, 0, 0, "clock_after_esc");
    tick_q.push_back(T + 68);
    key(T + 70, K_ESC, 1);

    key(T + 72, K_SPACE, 0);
    exp_at(T + 73, S_RUN, 0, 0, 1, 0, "run_after_clear");
    key(T + 74, K_SPACE, 1);
    key(T + 76, K_SPACE, 0);
    exp_at(T + 77, S_PAUSE, 0, 0, 1, 0, "pause_idle_entry");
    key(T + 78, K_SPACE, 1);

`ifdef STOPWATCH_AUTO_IDLE_EN
    exp_at(T + 106, S_PAUSE, 0, 0, 1, 0, "idle_before_timeout");
    exp_at(T + 107, S_CLOCK, 0, 1, 0, 0, "idle_timeout");
    b = T + 110;
`else
    exp_at(T + 1077, S_PAUSE, 0, 0, 1, 0, "no_idle_timeout");
    b = T + 1080;
`endif

    key(b, K_ESC, 0);
    exp_at(b + 1, S_CLOCK, 0, 1, 0, 0, "esc_to_clock");
    key(b + 2, K_ESC, 1);
    key(b + 4, K_ENTER, 1);
    key(b + 6, K_ENTER, 0);
    exp_at(b + 7, S_CLOCK, 0, 1, 0, 0, "enter_ignored");
    key(b + 8, K_SPACE, 0);
    exp_at(b + 9, S_RUN, 0, 0, 1, 0, "run_again");
    key(b + 10, K_ENTER, 1);
    key(b + 12, K_ENTER, 0);
    exp_at(b + 13, S_LAP, 0, 0, 1, 1, "lap_again");

    // Asynchronous reset mid-LAP, between clock edges
    goto(b + 15);
    #2;
    rst_n = 1'b0;
    exp_at(b + 15, S_CLOCK, 0, 1, 0, 0, "async_reset");
    exp_at(b + 16, S_CLOCK, 0, 1, 0, 0, "reset_held");
    goto(b + 17);
    rst_n = 1'b1;

    // Space still physically held but reset cleared its flag, so the make is accepted
    key(b + 18, K_SPACE, 0);
    exp_at(b + 19, S_RUN, 0, 0, 1, 0, "held_cleared");
    exp_at(b + 29, S_RUN, 1, 0, 1, 0, "tick_after_reset");
    tick_q.push_back(b + 29);

    goto(b + 35);
    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_done; i++) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
